// File: rtl/multicycle_ctrl.sv
// Multicycle controller FSM that sequences every Datapath control input per instruction class.
// Optional perf counters (instr_cnt, cycle_cnt) are built only when CTRL_PERF_EN is defined.
module multicycle_ctrl #(
  parameter int BOOT_WAIT = 2
`ifdef CTRL_PERF_EN
  , parameter int CNT_W = 16
`endif
) (
  input  logic             clk,
  input  logic             Rst,
  input  logic [4:0]       opcode,
  input  logic [1:0]       ALUopcode,
  input  logic [2:0]       PSW_NZC,
  output logic             Buff_MEMIns,
  output logic             ALUorNot,
  output logic             LIorMOV,
  output logic             MEMresource,
  output logic             WE_MEM,
  output logic             WBresource,
  output logic             RBresource,
  output logic             oprandB,
  output logic             LI,
  output logic             PCplus1orWB,
  output logic             WE_RF,
  output logic             Flag,
  output logic             ALUop,
  output logic             Buff_PSW,
  output logic             Branch,
  output logic [1:0]       Jump,
  output logic             Buff_PC,
  output logic             done,
  output logic             illegal,
`ifdef CTRL_PERF_EN
  output logic [CNT_W-1:0] instr_cnt,
  output logic [CNT_W-1:0] cycle_cnt,
`endif
  output logic [2:0]       state_o
);

  typedef enum logic [2:0] {
    S_BOOT, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
  } state_e;

  localparam logic [4:0] OP_ALU  = 5'b00000, OP_ADDI = 5'b00001, OP_SUBI = 5'b00010;
  localparam logic [4:0] OP_MOV  = 5'b00011, OP_LLI  = 5'b00100, OP_LHI  = 5'b00101;
  localparam logic [4:0] OP_LDRI = 5'b00110, OP_LDRR = 5'b00111, OP_STRI = 5'b01000;
  localparam logic [4:0] OP_STRR = 5'b01001, OP_OUTR = 5'b01010;
  localparam logic [4:0] OP_BCC  = 5'b10000, OP_BCS  = 5'b10001, OP_BNE  = 5'b10010;
  localparam logic [4:0] OP_BEQ  = 5'b10011, OP_BAL  = 5'b10100, OP_HLT  = 5'b11111;
  localparam logic [3:0] BOOT_LAST = 4'(BOOT_WAIT - 1);

  state_e     state_q, state_d;
  logic [3:0] boot_cnt_q, boot_cnt_d;
  logic [4:0] op_q, op_d;
  logic [1:0] func_q, func_d;
  logic       illegal_q, illegal_d;
  logic       unused_n;

  assign unused_n = PSW_NZC[2];
  assign state_o  = state_q;

  function automatic logic is_branch(input logic [4:0] op);
    return (op == OP_BCC) || (op == OP_BCS) || (op == OP_BNE) ||
           (op == OP_BEQ) || (op == OP_BAL);
  endfunction

  function automatic logic is_legal(input logic [4:0] op);
    return (op <= OP_OUTR) || is_branch(op) || (op == OP_HLT);
  endfunction

  function automatic logic is_ldr(input logic [4:0] op);
    return (op == OP_LDRI) || (op == OP_LDRR);
  endfunction

  function automatic logic is_str(input logic [4:0] op);
    return (op == OP_STRI) || (op == OP_STRR);
  endfunction

  // Instructions that retire in DECODE: branches, OUTR and unknown opcodes (NOP).
  function automatic logic is_short(input logic [4:0] op);
    return is_branch(op) || (op == OP_OUTR) || !is_legal(op);
  endfunction

  always_ff @(posedge clk) begin
    if (Rst) begin
      state_q    <= S_BOOT;
      boot_cnt_q <= 4'd0;
      op_q       <= 5'd0;
      func_q     <= 2'd0;
      illegal_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      boot_cnt_q <= boot_cnt_d;
      op_q       <= op_d;
      func_q     <= func_d;
      illegal_q  <= illegal_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    boot_cnt_d = boot_cnt_q;
    op_d       = op_q;
    func_d     = func_q;
    illegal_d  = illegal_q;
    case (state_q)
      S_BOOT: begin
        if (boot_cnt_q == BOOT_LAST) state_d = S_FETCH;
        else                         boot_cnt_d = boot_cnt_q + 4'd1;
      end
      S_FETCH: state_d = S_DECODE;
      S_DECODE: begin
        op_d   = opcode;
        func_d = ALUopcode;
        if (!is_legal(opcode)) illegal_d = 1'b1;
        if (opcode == OP_HLT)       state_d = S_HALT;
        else if (is_short(opcode))  state_d = S_FETCH;
        else                        state_d = S_EXEC;
      end
      S_EXEC:  state_d = S_MEM;
      S_MEM:   state_d = is_str(op_q) ? S_FETCH : S_WB;
      S_WB:    state_d = S_FETCH;
      S_HALT:  state_d = S_HALT;
      default: state_d = S_BOOT;
    endcase
  end

  // Outputs are forced low while Rst is high so an abort never emits a write or PC pulse.
  always_comb begin
    Buff_MEMIns = 1'b0; ALUorNot = 1'b0; LIorMOV  = 1'b0; MEMresource = 1'b0;
    WE_MEM      = 1'b0; WBresource = 1'b0; RBresource = 1'b0; oprandB = 1'b0;
    LI          = 1'b0; PCplus1orWB = 1'b0; WE_RF = 1'b0; Flag = 1'b0;
    ALUop       = 1'b0; Buff_PSW = 1'b0; Branch = 1'b0; Buff_PC = 1'b0;
    done        = 1'b0;
    if (!Rst) begin
      case (state_q)
        S_FETCH: Buff_MEMIns = 1'b1;
        S_DECODE: begin
          if (opcode == OP_LHI) begin
            RBresource = 1'b1;
            LI         = 1'b1;
          end
          if ((opcode == OP_ADDI) || (opcode == OP_SUBI) ||
              (opcode == OP_LDRI) || (opcode == OP_STRI)) oprandB = 1'b1;
          if (is_short(opcode) || (opcode == OP_HLT)) Buff_PC = 1'b1;
          case (opcode)
            OP_BCC:  Branch = ~PSW_NZC[0];
            OP_BCS:  Branch =  PSW_NZC[0];
            OP_BNE:  Branch = ~PSW_NZC[1];
            OP_BEQ:  Branch =  PSW_NZC[1];
            OP_BAL:  Branch = 1'b1;
            default: Branch = 1'b0;
          endcase
        end
        S_EXEC: begin
          case (op_q)
            OP_ALU: begin
              Flag     = func_q[0];
              ALUop    = func_q[1];
              Buff_PSW = 1'b1;
            end
            OP_ADDI: Buff_PSW = 1'b1;
            OP_SUBI: begin
              ALUop    = 1'b1;
              Buff_PSW = 1'b1;
            end
            default: ;
          endcase
          if (is_str(op_q)) RBresource = 1'b1;
        end
        S_MEM: begin
          if ((op_q == OP_LLI) || (op_q == OP_LHI)) ALUorNot = 1'b1;
          if (op_q == OP_MOV) begin
            ALUorNot = 1'b1;
            LIorMOV  = 1'b1;
          end
          if (is_ldr(op_q)) MEMresource = 1'b1;
          if (is_str(op_q)) begin
            MEMresource = 1'b1;
            WE_MEM      = 1'b1;
            Buff_PC     = 1'b1;
          end
        end
        S_WB: begin
          WE_RF       = 1'b1;
          Buff_PC     = 1'b1;
          PCplus1orWB = 1'b1;
          WBresource  = is_ldr(op_q);
        end
        S_HALT:  done = 1'b1;
        default: ;
      endcase
    end
  end

  assign Jump    = 2'b00;
  assign illegal = illegal_q & ~Rst;

`ifdef CTRL_PERF_EN
  logic [CNT_W-1:0] instr_cnt_q, cycle_cnt_q;

  always_ff @(posedge clk) begin
    if (Rst) begin
      instr_cnt_q <= '0;
      cycle_cnt_q <= '0;
    end else if ((state_q != S_BOOT) && (state_q != S_HALT)) begin
      cycle_cnt_q <= cycle_cnt_q + CNT_W'(1);
      if (Buff_PC) instr_cnt_q <= instr_cnt_q + CNT_W'(1);
    end
  end

  assign instr_cnt = instr_cnt_q;
  assign cycle_cnt = cycle_cnt_q;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: walks reset, boot, every instruction class, abort and halt.
module tb_multicycle_ctrl;

  logic       clk, Rst;
  logic [4:0] opcode;
  logic [1:0] ALUopcode;
  logic [2:0] PSW_NZC;
  logic Buff_MEMIns, ALUorNot, LIorMOV, MEMresource, WE_MEM, WBresource, RBresource;
  logic oprandB, LI, PCplus1orWB, WE_RF, Flag, ALUop, Buff_PSW, Branch, Buff_PC;
  logic done, illegal;
  logic [1:0] Jump;
  logic [2:0] state_o;
`ifdef CTRL_PERF_EN
  logic [15:0] instr_cnt, cycle_cnt;
`endif

  int checks = 0;
  int errors = 0;

  multicycle_ctrl #(.BOOT_WAIT(2)) dut (
    .clk(clk), .Rst(Rst), .opcode(opcode), .ALUopcode(ALUopcode), .PSW_NZC(PSW_NZC),
    .Buff_MEMIns(Buff_MEMIns), .ALUorNot(ALUorNot), .LIorMOV(LIorMOV),
    .MEMresource(MEMresource), .WE_MEM(WE_MEM), .WBresource(WBresource),
    .RBresource(RBresource), .oprandB(oprandB), .LI(LI), .PCplus1orWB(PCplus1orWB),
    .WE_RF(WE_RF), .Flag(Flag), .ALUop(ALUop), .Buff_PSW(Buff_PSW), .Branch(Branch),
    .Jump(Jump), .Buff_PC(Buff_PC), .done(done), .illegal(illegal),
`ifdef CTRL_PERF_EN
    .instr_cnt(instr_cnt), .cycle_cnt(cycle_cnt),
`endif
    .state_o(state_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observation vector: {Jump, done, illegal, 16 control bits}.
  localparam logic [19:0] MEMINS = 20'h08000, ALUORNOT = 20'h04000, LIORMOV = 20'h02000;
  localparam logic [19:0] MEMRES = 20'h01000, WEMEM    = 20'h00800, WBRES   = 20'h00400;
  localparam logic [19:0] RBRES  = 20'h00200, OPB      = 20'h00100, LIB     = 20'h00080;
  localparam logic [19:0] PCWB   = 20'h00040, WERF     = 20'h00020, FLAG    = 20'h00010;
  localparam logic [19:0] ALUOP  = 20'h00008, PSW      = 20'h00004, BR      = 20'h00002;
  localparam logic [19:0] BPC    = 20'h00001, ILL      = 20'h10000, DONE    = 20'h20000;
  localparam logic [19:0] WB_STD = WERF | BPC | PCWB;

  localparam logic [4:0] ALU = 5'b00000, ADDI = 5'b00001, SUBI = 5'b00010, MOV = 5'b00011;
  localparam logic [4:0] LLI = 5'b00100, LHI = 5'b00101, LDRI = 5'b00110, LDRR = 5'b00111;
  localparam logic [4:0] STRI = 5'b01000, OUTR = 5'b01010, BCC = 5'b10000, BCS = 5'b10001;
  localparam logic [4:0] BNE = 5'b10010, BEQ = 5'b10011, BAL = 5'b10100, HLT = 5'b11111;
  localparam logic [4:0] BAD = 5'b01111;

  logic [19:0] obs;
  assign obs = {Jump, done, illegal, Buff_MEMIns, ALUorNot, LIorMOV, MEMresource, WE_MEM,
                WBresource, RBresource, oprandB, LI, PCplus1orWB, WE_RF, Flag, ALUop,
                Buff_PSW, Branch, Buff_PC};

  // Drive inputs just after a posedge, compare on the following negedge, advance one cycle.
  task automatic step(input logic [4:0] op, input logic [1:0] fn, input logic [2:0] nzc,
                      input logic [19:0] exp, input string tag);
    opcode    = op;
    ALUopcode = fn;
    PSW_NZC   = nzc;
    @(negedge clk);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%05h expected=%05h", tag, obs, exp);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    Rst = 1'b1; opcode = '0; ALUopcode = '0; PSW_NZC = '0;
    @(posedge clk); #1;
    step(ALU, 0, 0, 0, "reset_a");
    step(ALU, 0, 0, 0, "reset_b");
    Rst = 1'b0;
    step(ALU, 0, 0, 0, "boot0");
    step(ALU, 0, 0, 0, "boot1");

    // LLI R1,FB ; LHI R1,FF ; LLI R2,03 ; ADD R1,R2,R1
    step(LLI, 0, 0, MEMINS,   "lli_fetch");
    step(LLI, 0, 0, 0,        "lli_dec");
    step(LLI, 0, 0, 0,        "lli_exec");
    step(LLI, 0, 0, ALUORNOT, "lli_mem");
    step(LLI, 0, 0, WB_STD,   "lli_wb");
    step(LHI, 0, 0, MEMINS,       "lhi_fetch");
    step(LHI, 0, 0, RBRES | LIB,  "lhi_dec");
    step(LHI, 0, 0, 0,            "lhi_exec");
    step(LHI, 0, 0, ALUORNOT,     "lhi_mem");
    step(LHI, 0, 0, WB_STD,       "lhi_wb");
    step(LLI, 0, 0, MEMINS,   "lli2_fetch");
    step(LLI, 0, 0, 0,        "lli2_dec");
    step(LLI, 0, 0, 0,        "lli2_exec");
    step(LLI, 0, 0, ALUORNOT, "lli2_mem");
    step(LLI, 0, 0, WB_STD,   "lli2_wb");
    step(ALU, 2'b00, 0, MEMINS, "add_fetch");
    step(ALU, 2'b00, 0, 0,      "add_dec");
    step(ALU, 2'b00, 0, PSW,    "add_exec");
    step(ALU, 2'b00, 0, 0,      "add_mem");
    step(ALU, 2'b00, 0, WB_STD, "add_wb");

    // Carry-using and subtracting ALU variants; func latched in DECODE, input changed after
    step(ALU, 2'b01, 0, MEMINS, "adc_fetch");
    step(ALU, 2'b01, 0, 0,      "adc_dec");
    step(ALU, 2'b00, 0, FLAG | PSW, "adc_exec");
    step(ALU, 2'b00, 0, 0,      "adc_mem");
    step(ALU, 2'b00, 0, WB_STD, "adc_wb");
    step(ALU, 2'b11, 0, MEMINS, "sbb_fetch");
    step(ALU, 2'b11, 0, 0,      "sbb_dec");
    step(ALU, 2'b11, 0, FLAG | ALUOP | PSW, "sbb_exec");
    step(ALU, 2'b11, 0, 0,      "sbb_mem");
    step(ALU, 2'b11, 0, WB_STD, "sbb_wb");
    step(SUBI, 0, 0, MEMINS,      "subi_fetch");
    step(SUBI, 0, 0, OPB,         "subi_dec");
    step(SUBI, 0, 0, ALUOP | PSW, "subi_exec");
    step(SUBI, 0, 0, 0,           "subi_mem");
    step(SUBI, 0, 0, WB_STD,      "subi_wb");
    step(ADDI, 0, 0, MEMINS, "addi_fetch");
    step(ADDI, 0, 0, OPB,    "addi_dec");
    step(ADDI, 0, 0, PSW,    "addi_exec");
    step(ADDI, 0, 0, 0,      "addi_mem");
    step(ADDI, 0, 0, WB_STD, "addi_wb");
    step(MOV, 0, 0, MEMINS,             "mov_fetch");
    step(MOV, 0, 0, 0,                  "mov_dec");
    step(MOV, 0, 0, 0,                  "mov_exec");
    step(MOV, 0, 0, ALUORNOT | LIORMOV, "mov_mem");
    step(MOV, 0, 0, WB_STD,             "mov_wb");

    // Branches: {N,Z,C}
    step(BCS, 0, 3'b001, MEMINS,   "bcs_fetch");
    step(BCS, 0, 3'b001, BR | BPC, "bcs_taken");
    step(BCC, 0, 3'b001, MEMINS,   "bcc_fetch");
    step(BCC, 0, 3'b001, BPC,      "bcc_not_taken");
    step(BCC, 0, 3'b000, MEMINS,   "bcc2_fetch");
    step(BCC, 0, 3'b000, BR | BPC, "bcc_taken");
    step(BNE, 0, 3'b010, MEMINS,   "bne_fetch");
    step(BNE, 0, 3'b010, BPC,      "bne_not_taken");
    step(BEQ, 0, 3'b010, MEMINS,   "beq_fetch");
    step(BEQ, 0, 3'b010, BR | BPC, "beq_taken");
    step(BAL, 0, 3'b100, MEMINS,   "bal_fetch");
    step(BAL, 0, 3'b100, BR | BPC, "bal_taken");
    step(OUTR, 0, 3'b111, MEMINS,  "outr_fetch");
    step(OUTR, 0, 3'b111, BPC,     "outr_dec");

    // STRri then LDRri to the same address
    step(STRI, 0, 0, MEMINS,                "str_fetch");
    step(STRI, 0, 0, OPB,                   "str_dec");
    step(STRI, 0, 0, RBRES,                 "str_exec");
    step(STRI, 0, 0, MEMRES | WEMEM | BPC,  "str_mem");
    step(LDRI, 0, 0, MEMINS,          "ldr_fetch");
    step(LDRI, 0, 0, OPB,             "ldr_dec");
    step(LDRI, 0, 0, 0,               "ldr_exec");
    step(LDRI, 0, 0, MEMRES,          "ldr_mem");
    step(LDRI, 0, 0, WB_STD | WBRES,  "ldr_wb");
    step(LDRR, 0, 0, MEMINS,          "ldrr_fetch");
    step(LDRR, 0, 0, 0,               "ldrr_dec");

    // Abort an ADD in EXEC: no Buff_PSW / WE_RF, then reboot
    step(LDRR, 0, 0, 0,      "ldrr_exec");
    step(LDRR, 0, 0, MEMRES, "ldrr_mem");
    step(LDRR, 0, 0, WB_STD | WBRES, "ldrr_wb");
    step(ALU, 0, 0, MEMINS, "abort_fetch");
    step(ALU, 0, 0, 0,      "abort_dec");
    Rst = 1'b1;
    step(ALU, 0, 0, 0, "abort_exec_rst");
    Rst = 1'b0;
    step(ALU, 0, 0, 0, "abort_boot0");
    step(ALU, 0, 0, 0, "abort_boot1");

    // Unknown opcode behaves as NOP and sets the sticky flag
    step(BAD, 0, 0, MEMINS,       "ill_fetch");
    step(BAD, 0, 0, BPC,          "ill_dec");
    step(LLI, 0, 0, MEMINS | ILL, "ill_sticky");
    step(LLI, 0, 0, ILL,          "ill_lli_dec");
    step(LLI, 0, 0, ILL,          "ill_lli_exec");
    step(LLI, 0, 0, ALUORNOT | ILL, "ill_lli_mem");
    step(LLI, 0, 0, WB_STD | ILL,   "ill_lli_wb");

    // HLT then frozen HALT with varying inputs
    step(HLT, 0, 0, MEMINS | ILL, "hlt_fetch");
    step(HLT, 0, 0, BPC | ILL,    "hlt_dec");
    for (int i = 0; i < 20; i++) begin
      step(5'(i), 2'(i), 3'(i), DONE | ILL, "halt_frozen");
    end
    Rst = 1'b1;
    step(HLT, 0, 0, 0, "halt_rst");
    Rst = 1'b0;
    step(HLT, 0, 0, 0, "post_rst_boot0");
    step(HLT, 0, 0, 0, "post_rst_boot1");
    step(HLT, 0, 0, MEMINS, "post_rst_fetch");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
